imm_encoder: RTL and testbench

- Inverse of the immediate-extend stage: scatters a 32-bit immediate into the RV32I immediate bit positions of an instruction word, for a given format.
- Sits in the instruction-generation/loader path, which builds or patches instruction words before they are written to instruction memory.
- Two-stage registered pipeline with valid/ready on both sides.
- Range-checks each immediate, flags violations per word and keeps a saturating error count.

---
 rtl/imm_encoder.sv | 131 +++++++++++++
 tb/tb_imm_encoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: places a 32-bit immediate into the RV32I immediate fields of an
// instruction word. The block is a two-stage valid/ready pipeline. It checks the
// range of each immediate and keeps a saturating count of errored words.
module imm_encoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             range_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);

  localparam logic [2:0] OP_I = 3'b000;
  localparam logic [2:0] OP_S = 3'b001;
  localparam logic [2:0] OP_B = 3'b010;
  localparam logic [2:0] OP_J = 3'b011;
  localparam logic [2:0] OP_U = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        a_valid;
  logic [2:0]  a_op;
  logic [31:0] a_imm;
  logic [31:0] a_base;
  logic        a_err;
  logic        b_valid;

  logic        a_adv;
  logic        b_adv;
  logic        in_err;
  logic [31:0] merged;

  // Pipeline advance depends only on stage state and downstream ready
  assign b_adv     = !b_valid || out_ready;
  assign a_adv     = !a_valid || b_adv;
  assign in_ready  = a_adv;
  assign out_valid = b_valid;

  // Range/alignment check on the incoming request (sign-extension test per field width)
  always_comb begin
    in_err = 1'b1;
    case (op)
      OP_I, OP_S: in_err = !((&imm[31:11]) || !(|imm[31:11]));
      OP_B:       in_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      OP_J:       in_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      OP_U:       in_err = |imm[11:0];
      default:    in_err = 1'b1;
    endcase
  end

  // Scatter the stage-A immediate over base; illegal ops pass base through
  always_comb begin
    merged = a_base;
    case (a_op)
      OP_I: merged[31:20] = a_imm[11:0];
      OP_S: begin
        merged[31:25] = a_imm[11:5];
        merged[11:7]  = a_imm[4:0];
      end
      OP_B: begin
        merged[31]    = a_imm[12];
        merged[30:25] = a_imm[10:5];
        merged[11:8]  = a_imm[4:1];
        merged[7]     = a_imm[11];
      end
      OP_J: begin
        merged[31]    = a_imm[20];
        merged[30:21] = a_imm[10:1];
        merged[20]    = a_imm[11];
        merged[19:12] = a_imm[19:12];
      end
      OP_U: merged[31:12] = a_imm[31:12];
      default: ;
    endcase
  end

  // Stage A: capture the request and its error bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_op    <= 3'b000;
      a_imm   <= 32'h0;
      a_base  <= 32'h0;
      a_err   <= 1'b0;
    end else if (a_adv) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_op   <= op;
        a_imm  <= imm;
        a_base <= base;
        a_err  <= in_err;
      end
    end
  end

  // Stage B: hold the merged word until downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid   <= 1'b0;
      inst      <= 32'h0;
      range_err <= 1'b0;
    end else if (b_adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        inst      <= merged;
        range_err <= a_err;
      end
    end
  end

  // Saturating count of errored words delivered; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (b_valid && out_ready && range_err && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: vector table plus hand sequences, with a scoreboard queue
// that is filled on accept and drained on delivery.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_ready;
  logic        clr_err;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] inst,      inst2;
  logic        range_err, range_err2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .imm(imm), .base(base), .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .range_err(range_err), .err_count(err_count), .clr_err(clr_err)
  );

  imm_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .imm(imm), .base(base), .out_valid(out_valid2), .out_ready(out_ready),
    .inst(inst2), .range_err(range_err2), .err_count(err_count2), .clr_err(clr_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl[18];
  logic [31:0] cur_inst;
  logic        cur_err;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          n_out = 0;
  int          exp_cnt8 = 0;
  int          exp_cnt2 = 0;
  int          occ;
  logic        rand_bp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference encoder: concatenation form with signed range compares
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] i, input logic [31:0] b);
    exp_t r;
    int   s;
    s = $signed(i);
    r.inst = b;
    r.err  = 1'b1;
    case (o)
      3'd0: begin r.inst = {i[11:0], b[19:0]}; r.err = !(s >= -2048 && s <= 2047); end
      3'd1: begin r.inst = {i[11:5], b[24:12], i[4:0], b[6:0]}; r.err = !(s >= -2048 && s <= 2047); end
      3'd2: begin r.inst = {i[12], i[10:5], b[24:12], i[4:1], i[11], b[6:0]};
                  r.err = i[0] || !(s >= -4096 && s <= 4094); end
      3'd3: begin r.inst = {i[20], i[10:1], i[11], i[19:12], b[11:0]};
                  r.err = i[0] || !(s >= -1048576 && s <= 1048574); end
      3'd4: begin r.inst = {i[31:12], b[11:0]}; r.err = (i[11:0] != 12'h0); end
      default: ;
    endcase
    return r;
  endfunction

  // Scoreboard: in_ready/err_count model, pop on delivery, push on accept
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      logic hs_err;
      occ = q.size();
      chk("in_ready", {31'h0, in_ready}, {31'h0, (occ < 2) || out_ready});
      chk("in_ready_w2", {31'h0, in_ready2}, {31'h0, (occ < 2) || out_ready});
      chk("err_count", {24'h0, err_count}, 32'(exp_cnt8));
      chk("err_count_w2", {30'h0, err_count2}, 32'(exp_cnt2));
      hs_err = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = q.pop_front();
          chk("inst", inst, e.inst);
          chk("range_err", {31'h0, range_err}, {31'h0, e.err});
          chk("inst_w2", inst2, e.inst);
          chk("out_valid_w2", {31'h0, out_valid2}, 32'h1);
          hs_err = e.err;
          n_out++;
        end
      end
      if (clr_err) begin
        exp_cnt8 = 0;
        exp_cnt2 = 0;
      end else if (hs_err) begin
        if (exp_cnt8 < 255) exp_cnt8++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
      if (in_valid && in_ready) begin
        e.inst = cur_inst;
        e.err  = cur_err;
        q.push_back(e);
        n_acc++;
      end
    end
  end

  // Random backpressure, changed away from both clock edges
  always @(posedge clk) begin
    if (rand_bp) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive(input vec_t v);
    op = v.op; imm = v.imm; base = v.base; cur_inst = v.inst; cur_err = v.err;
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] i, input logic [31:0] b,
                      input logic [31:0] ei, input logic ee);
    int start;
    start = n_acc;
    op = o; imm = i; base = b; cur_inst = ei; cur_err = ee;
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (n_acc != start) break;
    end
    if (n_acc == start) fail_now("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200; c++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp[3];
    int   start, k, nerr, out0;
    exp_t e;
    logic [31:0] x, im, b;
    logic [2:0]  o;

    tbl[0]  = '{3'd1, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 1'b0};
    tbl[1]  = '{3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    tbl[2]  = '{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
    tbl[3]  = '{3'd3, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0};
    tbl[4]  = '{3'd0, 32'hFFFF_F800, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[5]  = '{3'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0};
    tbl[6]  = '{3'd2, 32'h0000_0FFE, 32'h0000_0000, 32'h7E00_0F80, 1'b0};
    tbl[7]  = '{3'd3, 32'h000F_FFFE, 32'h0000_0000, 32'h7FFF_F000, 1'b0};
    tbl[8]  = '{3'd3, 32'hFFF0_0000, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[9]  = '{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    tbl[10] = '{3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
    tbl[11] = '{3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    tbl[12] = '{3'd2, 32'h0000_1000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    tbl[13] = '{3'd3, 32'h0000_0001, 32'h0000_006F, 32'h0000_006F, 1'b1};
    tbl[14] = '{3'd4, 32'h0000_0001, 32'h0000_0037, 32'h0000_0037, 1'b1};
    tbl[15] = '{3'd1, 32'hFFFF_F7FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b1};
    tbl[16] = '{3'd5, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1};
    tbl[17] = '{3'd3, 32'h0010_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; imm = 32'h0; base = 32'h0;
    out_ready = 1'b0; clr_err = 1'b0; cur_inst = 32'h0; cur_err = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_range_err", {31'h0, range_err}, 32'h0);
    chk("rst_err_count", {24'h0, err_count}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Latency: stage A after accept edge, output one edge later
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    chk("lat_not_yet", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("lat_out_valid", {31'h0, out_valid}, 32'h1);
    chk("lat_inst", inst, 32'hFFF0_0013);
    chk("lat_range_err", {31'h0, range_err}, 32'h0);
    wait_drain();

    // Vector table, back-to-back with out_ready high
    nerr = 0;
    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].imm, tbl[i].base, tbl[i].inst, tbl[i].err);
      if (tbl[i].err) nerr++;
    end
    wait_drain();
    chk("tbl_err_count", {24'h0, err_count}, 32'(nerr));
    chk("tbl_err_count_w2", {30'h0, err_count2}, 32'h3);

    // Error counting sequence from a cleared counter
    pulse_clr();
    chk("clr_idle", {24'h0, err_count}, 32'h0);
    send(3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    wait_drain();
    chk("err1", {24'h0, err_count}, 32'h1);
    send(3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    wait_drain();
    chk("err2", {24'h0, err_count}, 32'h2);
    send(3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    wait_drain();
    chk("err3", {24'h0, err_count}, 32'h3);
    chk("err3_w2", {30'h0, err_count2}, 32'h3);

    // Clear coincident with a fourth errored handshake
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    for (int c = 0; c < 20 && !out_valid; c++) begin @(posedge clk); #1; end
    if (!out_valid) fail_now("clr_wait_valid");
    clr_err = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clr_wins", {24'h0, err_count}, 32'h0);
    chk("clr_wins_w2", {30'h0, err_count2}, 32'h0);
    wait_drain();

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++)
      send(3'd7, 32'h0, 32'(i), 32'(i), 1'b1);
    wait_drain();
    chk("sat_w8", {24'h0, err_count}, 32'h5);
    chk("sat_w2", {30'h0, err_count2}, 32'h3);

    // Backpressure: three offered, two accepted, output held
    bp[0] = '{3'd0, 32'h1, 32'h13, 32'h0010_0013, 1'b0};
    bp[1] = '{3'd0, 32'h2, 32'h13, 32'h0020_0013, 1'b0};
    bp[2] = '{3'd0, 32'h3, 32'h13, 32'h0030_0013, 1'b0};
    out_ready = 1'b0;
    start = n_acc; k = 0;
    drive(bp[0]);
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (n_acc - start > k) begin
        k++;
        if (k < 3) drive(bp[k]); else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", 32'(n_acc - start), 32'h2);
    chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_hold_inst", inst, 32'h0010_0013);
    @(posedge clk); #1;
    chk("bp_hold_inst2", inst, 32'h0010_0013);
    chk("bp_hold_err", {31'h0, range_err}, 32'h0);
    out_ready = 1'b1;
    out0 = n_out;
    repeat (3) begin
      @(posedge clk); #1;
      if (n_acc - start > k) begin
        k++;
        if (k < 3) drive(bp[k]); else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 32'(n_acc - start), 32'h3);
    chk("bp_one_per_cycle", 32'(n_out - out0), 32'h3);
    wait_drain();

    // Random words under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: im = x;
        1: im = {{20{x[11]}}, x[11:0]};
        2: im = {{11{x[20]}}, x[20:1], 1'b0};
        default: im = {x[31:12], 12'h0};
      endcase
      b = $urandom;
      e = model(o, im, b);
      send(o, im, b, e.inst, e.err);
    end
    rand_bp = 1'b0;
    @(posedge clk); #3;
    out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset with two errored words in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd7, 32'h0, 32'hAAAA_0001, 32'hAAAA_0001, 1'b1);
    send(3'd7, 32'h0, 32'hAAAA_0002, 32'hAAAA_0002, 1'b1);
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_err_count", {24'h0, err_count}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rel_err_count", {24'h0, err_count}, 32'h0);
    out_ready = 1'b1;
    out0 = n_out;
    repeat (5) @(posedge clk);
    #1;
    chk("rel_no_stale", 32'(n_out - out0), 32'h0);
    chk("rel_out_valid", {31'h0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
